// File: rtl/cache_arbiter_if.sv
// Bus bundle between the icache, the dcache, the RAM and the arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface cache_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dburst;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, dburst, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, dburst, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates one RAM port between icache and dcache: dcache priority with a
// starvation limit for the icache, plus locked two-word dcache bursts.
module cache_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_starve;
  logic [3:0] w_starve_next;
  logic       r_lock;
  logic       w_lock_next;
  logic       w_dreq;

  assign w_dreq = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_starve <= 4'd0;
      r_lock   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
      r_lock   <= w_lock_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve;
    w_lock_next   = r_lock;
    bus.ramREN    = 1'b0;
    bus.ramWEN    = 1'b0;
    bus.ramaddr   = 32'd0;
    bus.ramstore  = 32'd0;
    bus.iwait     = 1'b1;
    bus.iload     = 32'd0;
    bus.dwait     = 1'b1;
    bus.dload     = 32'd0;

    case (r_state)
      IDLE: begin
        if (!bus.iREN) begin
          w_starve_next = 4'd0;
        end
        if (w_dreq && (r_starve < STARVE_LIM)) begin
          w_state_next = DGRANT;
        end else if (bus.iREN && ((r_starve == STARVE_LIM) || !w_dreq)) begin
          w_state_next = IGRANT;
        end
      end

      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        // A dropped request aborts silently, even if the RAM answers now.
        if (!bus.iREN) begin
          w_state_next = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          bus.iwait     = 1'b0;
          bus.iload     = bus.ramload;
          w_starve_next = 4'd0;
          w_state_next  = IDLE;
        end else if (bus.ramstate == RAM_ERROR) begin
          w_state_next = IDLE;
        end
      end

      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = ~bus.dWEN;
        if (!w_dreq) begin
          w_lock_next  = 1'b0;
          w_state_next = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
          if (bus.iREN && (r_starve < STARVE_LIM)) begin
            w_starve_next = r_starve + 4'd1;
          end
          // First word of a burst keeps the grant for the second word.
          if (bus.dburst && !r_lock) begin
            w_lock_next = 1'b1;
          end else begin
            w_lock_next  = 1'b0;
            w_state_next = IDLE;
          end
        end else if (bus.ramstate == RAM_ERROR) begin
          w_lock_next  = 1'b0;
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: hand-computed spot checks plus a
// per-cycle comparison against an ownership-level reference model.
module tb_cache_arbiter;
  localparam int SMAX = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  cache_arbiter_if bus();

  cache_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ren"},   32'(bus.ramREN), 32'd0);
    chk({name, "_wen"},   32'(bus.ramWEN), 32'd0);
    chk({name, "_addr"},  bus.ramaddr, 32'd0);
    chk({name, "_store"}, bus.ramstore, 32'd0);
    chk({name, "_waits"}, {30'd0, bus.iwait, bus.dwait}, 32'd3);
    chk({name, "_loads"}, bus.iload | bus.dload, 32'd0);
  endtask

  // Reference model: who owns the RAM, how many dcache wins the waiting
  // icache has suffered, and whether the next dcache word is a burst tail.
  typedef struct packed {
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } obs_t;

  int m_owner  = 0;  // 0 nobody, 1 icache, 2 dcache
  int m_dwins  = 0;
  bit m_second = 1'b0;
  bit m_live   = 1'b0;

  always @(negedge CLK) begin
    obs_t e;
    obs_t a;
    bit   dreq;
    dreq = bus.dREN || bus.dWEN;
    e = '{iwait: 1'b1, iload: 32'd0, dwait: 1'b1, dload: 32'd0,
          ren: 1'b0, wen: 1'b0, addr: 32'd0, store: 32'd0};
    if (m_owner == 1) begin
      e.ren  = 1'b1;
      e.addr = bus.iaddr;
      if (bus.iREN && bus.ramstate == 2'd2) begin
        e.iwait = 1'b0;
        e.iload = bus.ramload;
      end
    end else if (m_owner == 2) begin
      e.addr  = bus.daddr;
      e.store = bus.dstore;
      e.wen   = bus.dWEN;
      e.ren   = !bus.dWEN;
      if (dreq && bus.ramstate == 2'd2) begin
        e.dwait = 1'b0;
        e.dload = bus.ramload;
      end
    end
    a = '{iwait: bus.iwait, iload: bus.iload, dwait: bus.dwait, dload: bus.dload,
          ren: bus.ramREN, wen: bus.ramWEN, addr: bus.ramaddr, store: bus.ramstore};
    if (m_live) begin
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL model t=%0t: got %h expected %h", $time, a, e);
      end
      n_vec++;
      if ((bus.ramREN && bus.ramWEN) || (!bus.iwait && !bus.dwait)) begin
        n_bad++;
        $display("FAIL exclusive t=%0t: got ren/wen=%b%b waits=%b%b required not both active",
                 $time, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait);
      end
    end
    // Advance to the state seen after the coming rising edge.
    if (!nRST) begin
      m_owner  = 0;
      m_dwins  = 0;
      m_second = 1'b0;
      m_live   = 1'b1;
    end else if (m_owner == 0) begin
      if (dreq && m_dwins < SMAX) m_owner = 2;
      else if (bus.iREN)          m_owner = 1;
      if (!bus.iREN) m_dwins = 0;
    end else if (m_owner == 1) begin
      if (!bus.iREN || bus.ramstate == 2'd3) begin
        m_owner = 0;
      end else if (bus.ramstate == 2'd2) begin
        m_owner = 0;
        m_dwins = 0;
      end
    end else begin
      if (!dreq || bus.ramstate == 2'd3) begin
        m_owner  = 0;
        m_second = 1'b0;
      end else if (bus.ramstate == 2'd2) begin
        if (bus.iREN && m_dwins < SMAX) m_dwins++;
        if (bus.dburst && !m_second) begin
          m_second = 1'b1;
        end else begin
          m_owner  = 0;
          m_second = 1'b0;
        end
      end
    end
  end

  byte q[$];

  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = 32'd0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;
    bus.dburst = 1'b0; bus.ramload = 32'd0; bus.ramstate = 2'd0;
    tick(); tick(); look();
    chk_idle("reset");

    // Single icache read with two BUSY cycles.
    tick(); nRST = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
    look(); chk("t1_c0_ren", 32'(bus.ramREN), 32'd0);
    tick(); look();
    chk("t1_c1_ren", 32'(bus.ramREN), 32'd1);
    chk("t1_c1_addr", bus.ramaddr, 32'h40);
    chk("t1_c1_iwait", 32'(bus.iwait), 32'd1);
    tick(); look(); chk("t1_c2_iwait", 32'(bus.iwait), 32'd1);
    tick(); bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
    look();
    chk("t1_c3_iwait", 32'(bus.iwait), 32'd0);
    chk("t1_c3_iload", bus.iload, 32'hDEADBEEF);
    tick(); bus.iREN = 1'b0; bus.ramstate = 2'd0;
    look(); chk_idle("t1_c4");

    // Simultaneous icache read and dcache write: dcache goes first.
    tick(); bus.iREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    bus.ramstate = 2'd2; bus.ramload = 32'h55AA;
    look(); chk("t2_c0_wen", 32'(bus.ramWEN), 32'd0);
    tick(); look();
    chk("t2_c1_wen", 32'(bus.ramWEN), 32'd1);
    chk("t2_c1_ren", 32'(bus.ramREN), 32'd0);
    chk("t2_c1_addr", bus.ramaddr, 32'h80);
    chk("t2_c1_store", bus.ramstore, 32'h1234);
    chk("t2_c1_waits", {30'd0, bus.iwait, bus.dwait}, 32'd2);
    tick(); bus.dWEN = 1'b0;
    look(); chk("t2_c2_ren", 32'(bus.ramREN), 32'd0);
    tick(); look();
    chk("t2_c3_addr", bus.ramaddr, 32'h40);
    chk("t2_c3_iwait", 32'(bus.iwait), 32'd0);
    chk("t2_c3_iload", bus.iload, 32'h55AA);
    tick(); bus.iREN = 1'b0;
    look(); chk_idle("t2_c4");

    // Both caches hammering: four dcache wins, then one icache win.
    tick(); bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = 2'd2;
    for (int i = 0; i < 24; i++) begin
      look();
      if (!bus.dwait) q.push_back("D");
      if (!bus.iwait) q.push_back("I");
      tick();
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    chk("t3_count", 32'(q.size()), 32'd12);
    for (int k = 0; k < 10 && k < q.size(); k++) begin
      chk($sformatf("t3_order%0d", k), 32'(q[k]), (k % 5 == 4) ? 32'h49 : 32'h44);
    end
    look();

    // Locked two-word dcache burst while icache waits.
    tick(); look();
    tick(); bus.iREN = 1'b1; bus.dREN = 1'b1; bus.dburst = 1'b1; bus.daddr = 32'h100;
    bus.ramload = 32'hA0A0;
    look(); chk("t4_c0_ren", 32'(bus.ramREN), 32'd0);
    tick(); look();
    chk("t4_c1_dwait", 32'(bus.dwait), 32'd0);
    chk("t4_c1_addr", bus.ramaddr, 32'h100);
    tick(); bus.daddr = 32'h104; bus.ramload = 32'hB0B0;
    look();
    chk("t4_c2_dwait", 32'(bus.dwait), 32'd0);
    chk("t4_c2_addr", bus.ramaddr, 32'h104);
    chk("t4_c2_dload", bus.dload, 32'hB0B0);
    chk("t4_c2_iwait", 32'(bus.iwait), 32'd1);
    tick(); bus.dREN = 1'b0; bus.dburst = 1'b0;
    look(); chk_idle("t4_c3");
    tick(); look(); chk("t4_c4_iwait", 32'(bus.iwait), 32'd0);
    tick(); bus.iREN = 1'b0; bus.dREN = 1'b1; bus.dburst = 1'b1; bus.daddr = 32'h108;
    look();
    tick(); look(); chk("t4_c6_dwait", 32'(bus.dwait), 32'd0);
    tick(); bus.dREN = 1'b0; bus.dburst = 1'b0;
    look();
    chk("t4_c7_ren", 32'(bus.ramREN), 32'd1);
    chk("t4_c7_dwait", 32'(bus.dwait), 32'd1);
    tick(); look(); chk_idle("t4_c8");

    // RAM error during a dcache read, then retry.
    tick(); bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = 2'd3;
    look();
    tick(); look();
    chk("t5_c1_ren", 32'(bus.ramREN), 32'd1);
    chk("t5_c1_addr", bus.ramaddr, 32'h200);
    chk("t5_c1_dwait", 32'(bus.dwait), 32'd1);
    tick(); look(); chk("t5_c2_ren", 32'(bus.ramREN), 32'd0);
    tick(); bus.ramstate = 2'd2; bus.ramload = 32'hC0C0;
    look();
    chk("t5_c3_addr", bus.ramaddr, 32'h200);
    chk("t5_c3_dwait", 32'(bus.dwait), 32'd0);
    chk("t5_c3_dload", bus.dload, 32'hC0C0);
    tick(); bus.dREN = 1'b0;
    look(); chk_idle("t5_c4");

    // Reset during a BUSY icache grant, then an icache request drop.
    tick(); bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
    look();
    tick(); nRST = 1'b0;
    look(); chk("t6_c1_ren", 32'(bus.ramREN), 32'd1);
    tick(); nRST = 1'b1; bus.iREN = 1'b0; bus.ramstate = 2'd2;
    look(); chk_idle("t6_c2");
    tick(); look(); chk_idle("t6_c3");
    tick(); bus.iREN = 1'b1; bus.ramstate = 2'd1;
    look();
    tick(); look(); chk("t6_c5_ren", 32'(bus.ramREN), 32'd1);
    tick(); bus.iREN = 1'b0; bus.ramstate = 2'd2; bus.ramload = 32'hEE;
    look();
    chk("t6_c6_iwait", 32'(bus.iwait), 32'd1);
    chk("t6_c6_iload", bus.iload, 32'd0);
    tick(); look(); chk_idle("t6_c7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
